fft_addr_sequencer: RTL and testbench
=====================================

# fft_addr_sequencer

Control stage directly downstream of the AXI bridge: it starts when the bridge reports the sample buffer loaded. It walks a radix-2 decimation-in-frequency FFT over the sample RAM, issuing one butterfly command (address pair plus twiddle index) per handshake to the butterfly datapath. It tracks write-backs so that no stage begins before the previous one has fully landed in RAM. It raises the calculation-complete level that the bridge uses to enable its read path.

## Interface
- ADDR_WIDTH, 12: sample RAM index width; N at most 2^(ADDR_WIDTH-1).
- TW_WIDTH, 11: twiddle table index width (table holds N_max/2 entries).
- STAGE_WIDTH, 4: stage counter width; must hold log2(N_max).
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_DATA_LOADED  in  1  start pulse from bridge; sampled only in IDLE or DONE.
- i_SAMPLES_NUMBER  in  ADDR_WIDTH  transform length N; captured on start.
- o_BF_VALID  out  1  butterfly command valid.
- i_BF_READY  in  1  butterfly unit accepts command.
- o_ADDR_A  out  ADDR_WIDTH  upper-wing sample index.
- o_ADDR_B  out  ADDR_WIDTH  lower-wing sample index (A + span).
- o_TWIDDLE  out  TW_WIDTH  twiddle index k into an N_max-point table.
- o_STAGE  out  STAGE_WIDTH  current stage number.
- i_WB_DONE  in  1  one pulse per butterfly result written back to RAM.
- o_BUSY  out  1  high from start until DONE.
- o_CALC_END  out  1  level; high in DONE until the next start.
- o_ERR  out  1  sticky error; cleared on next accepted start.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- Start (IDLE or DONE, i_DATA_LOADED=1):
  - Capture N.
  - Compute L = log2(N).
  - Clear stage, j and base counters, plus the outstanding counter and o_ERR.
  - Valid N is a power of two with 4 ≤ N ≤ 2^(ADDR_WIDTH-1). Valid N goes to ISSUE.
  - Invalid N sets o_ERR and goes to IDLE; no command is issued and o_CALC_END stays 0.
- Stage s, span = N >> (s+1).
  - Butterfly addresses: A = base + j, B = A + span, twiddle = j << (s + log2(N_max/N)).
  - On each transfer (o_BF_VALID & i_BF_READY): j increments. When j = span-1, j returns to 0 and base += 2*span.
  - The transfer that issues butterfly number N/2-1 of the stage moves the FSM to DRAIN.
- Outstanding counter (ADDR_WIDTH bits):
  - +1 per transfer, -1 per i_WB_DONE.
  - Both in the same cycle leave it unchanged.
  - i_WB_DONE with counter 0 and no transfer that cycle: o_ERR=1, counter stays 0.
- DRAIN, counter next value = 0:
  - If s = L-1, go to DONE.
  - Otherwise s++, base = j = 0, go to ISSUE.
- DONE: o_CALC_END=1, o_BUSY=0; the FSM holds until a new start.
- Output ordering is bit-reversed in RAM. Reordering is the read path's job, not this block's.
- i_DATA_LOADED during ISSUE or DRAIN is ignored.

## Timing
- Reset values:
  - o_BF_VALID, o_BUSY, o_CALC_END and o_ERR are 0.
  - o_ADDR_A, o_ADDR_B, o_TWIDDLE and o_STAGE are 0.
  - State is IDLE.
- Start to first o_BF_VALID: 1 cycle. The start edge loads the registers, and o_BF_VALID is high in the following cycle.
- o_BF_VALID is combinational from state (ISSUE).
- Addresses, twiddle and stage are registered. They stay stable while o_BF_VALID & !i_BF_READY.
- With i_BF_READY tied high, throughput is one butterfly per cycle within a stage.
- o_BF_VALID is low for the entire DRAIN state.
- The edge that completes the final drain enters DONE; o_CALC_END is high in the next cycle.
- DONE to restart: the start edge drops o_CALC_END and raises o_BUSY in the next cycle.
- Reset asserted mid-transform: all outputs return to their reset values immediately, and counters clear.

## Test plan
- N=8, i_BF_READY=1, i_WB_DONE one cycle after each transfer, N_max=2048 (twiddle shift +8):
  - Stage 0 issues (0,4,0),(1,5,256),(2,6,512),(3,7,768).
  - Stage 1 issues (0,2,0),(1,3,512),(4,6,0),(5,7,512).
  - Stage 2 issues (0,1,0),(2,3,0),(4,5,0),(6,7,0).
  - o_CALC_END rises after the 12th write-back.
- Backpressure: toggle i_BF_READY randomly with N=16.
  - Addresses hold during stalls.
  - Exactly 32 transfers occur, each address pair issued once per stage.
- Drain hazard: N=8 with i_WB_DONE withheld for 20 cycles after stage 0.
  - o_BF_VALID stays 0 until the 4th write-back.
  - Stage 1 starts the cycle after it.
- Invalid length: N=6, then N=2, then N=4096 truncated to 0.
  - Each asserts o_ERR with no o_BF_VALID.
  - A following start with N=4 clears o_ERR and completes.
- Full size: N=2048.
  - 11264 transfers, o_STAGE reaching 10, o_CALC_END high.
  - Restart clears o_CALC_END the following cycle.
- Reset mid-op: assert i_rstn=0 during stage 1 of N=64.
  - All outputs go to 0 immediately.
  - A fresh start after reset produces stage-0 command (0,32,0).

Source files
------------

// File: rtl/fft_addr_sequencer.sv
// Radix-2 DIF FFT address sequencer: issues butterfly address pairs and twiddle indices stage by
// stage, and holds each stage boundary until every write-back of the previous stage has landed.
module fft_addr_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned TW_WIDTH    = 11,
  parameter int unsigned STAGE_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_DATA_LOADED,
  input  logic [ADDR_WIDTH-1:0]  i_SAMPLES_NUMBER,
  output logic                   o_BF_VALID,
  input  logic                   i_BF_READY,
  output logic [ADDR_WIDTH-1:0]  o_ADDR_A,
  output logic [ADDR_WIDTH-1:0]  o_ADDR_B,
  output logic [TW_WIDTH-1:0]    o_TWIDDLE,
  output logic [STAGE_WIDTH-1:0] o_STAGE,
  input  logic                   i_WB_DONE,
  output logic                   o_BUSY,
  output logic                   o_CALC_END,
  output logic                   o_ERR
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  n_q, n_d;
  logic [STAGE_WIDTH-1:0] log_n_q, log_n_d;
  logic [STAGE_WIDTH-1:0] stage_q, stage_d;
  logic [ADDR_WIDTH-1:0]  j_q, j_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [ADDR_WIDTH-1:0]  bf_cnt_q, bf_cnt_d;
  logic [ADDR_WIDTH-1:0]  outst_q, outst_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0]  addr_b_q, addr_b_d;
  logic [TW_WIDTH-1:0]    tw_q, tw_d;

  logic                   xfer;
  logic                   n_valid;
  logic [ADDR_WIDTH-1:0]  span;
  logic [ADDR_WIDTH-1:0]  span_d;
  logic [STAGE_WIDTH-1:0] tw_sh;

  function automatic logic [STAGE_WIDTH-1:0] log2_of(input logic [ADDR_WIDTH-1:0] v);
    log2_of = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (v[i]) log2_of = STAGE_WIDTH'(i);
    end
  endfunction

  assign o_BF_VALID = (state_q == StIssue);
  assign o_BUSY     = (state_q == StIssue) || (state_q == StDrain);
  assign o_CALC_END = (state_q == StDone);
  assign o_ERR      = err_q;
  assign o_ADDR_A   = addr_a_q;
  assign o_ADDR_B   = addr_b_q;
  assign o_TWIDDLE  = tw_q;
  assign o_STAGE    = stage_q;

  assign xfer = o_BF_VALID & i_BF_READY;
  assign span = n_q >> (stage_q + STAGE_WIDTH'(1));
  // Any power of two that fits in ADDR_WIDTH bits is at most 2^(ADDR_WIDTH-1).
  assign n_valid = ((i_SAMPLES_NUMBER & (i_SAMPLES_NUMBER - ADDR_WIDTH'(1))) == '0) &&
                   (i_SAMPLES_NUMBER >= ADDR_WIDTH'(4));

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    log_n_d  = log_n_q;
    stage_d  = stage_q;
    j_d      = j_q;
    base_d   = base_q;
    bf_cnt_d = bf_cnt_q;
    outst_d  = outst_q;
    err_d    = err_q;

    if (xfer && !i_WB_DONE) begin
      outst_d = outst_q + ADDR_WIDTH'(1);
    end else if (!xfer && i_WB_DONE) begin
      if (outst_q == '0) err_d = 1'b1;
      else               outst_d = outst_q - ADDR_WIDTH'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (i_DATA_LOADED) begin
          n_d      = i_SAMPLES_NUMBER;
          log_n_d  = log2_of(i_SAMPLES_NUMBER);
          stage_d  = '0;
          j_d      = '0;
          base_d   = '0;
          bf_cnt_d = '0;
          outst_d  = '0;
          err_d    = !n_valid;
          state_d  = n_valid ? StIssue : StIdle;
        end
      end
      StIssue: begin
        if (i_BF_READY) begin
          if (bf_cnt_q == (n_q >> 1) - ADDR_WIDTH'(1)) begin
            bf_cnt_d = '0;
            j_d      = '0;
            base_d   = '0;
            state_d  = StDrain;
          end else begin
            bf_cnt_d = bf_cnt_q + ADDR_WIDTH'(1);
            if (j_q == span - ADDR_WIDTH'(1)) begin
              j_d    = '0;
              base_d = base_q + (span << 1);
            end else begin
              j_d    = j_q + ADDR_WIDTH'(1);
            end
          end
        end
      end
      StDrain: begin
        // Next stage reads what this one wrote, so wait for every write-back.
        if (outst_d == '0) begin
          if (stage_q == log_n_q - STAGE_WIDTH'(1)) begin
            state_d = StDone;
          end else begin
            stage_d = stage_q + STAGE_WIDTH'(1);
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Command registers follow the next counter values so they line up with o_BF_VALID.
    span_d   = n_d >> (stage_d + STAGE_WIDTH'(1));
    tw_sh    = stage_d + STAGE_WIDTH'(ADDR_WIDTH - 1) - log_n_d;
    addr_a_d = base_d + j_d;
    addr_b_d = base_d + j_d + span_d;
    tw_d     = TW_WIDTH'(j_d << tw_sh);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= StIdle;
      n_q      <= '0;
      log_n_q  <= '0;
      stage_q  <= '0;
      j_q      <= '0;
      base_q   <= '0;
      bf_cnt_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      log_n_q  <= log_n_d;
      stage_q  <= stage_d;
      j_q      <= j_d;
      base_q   <= base_d;
      bf_cnt_q <= bf_cnt_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
    end
  end

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Scoreboard bench for fft_addr_sequencer: expected butterfly commands are queued from a
// reference FFT walk at each start and popped on every observed transfer.
module tb_fft_addr_sequencer;
  localparam int AW = 12;
  localparam int TW = 11;
  localparam int SW = 4;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          dl;
  logic [AW-1:0] nsamp;
  logic          bf_valid;
  logic          rdy;
  logic [AW-1:0] a;
  logic [AW-1:0] b;
  logic [TW-1:0] tw;
  logic [SW-1:0] st;
  logic          wb;
  logic          busy;
  logic          cend;
  logic          err;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [TW-1:0] tw;
    logic [SW-1:0] st;
  } cmd_t;

  cmd_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wb_owed = 0;
  bit   wb_hold = 0;

  fft_addr_sequencer #(.ADDR_WIDTH(AW), .TW_WIDTH(TW), .STAGE_WIDTH(SW)) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_DATA_LOADED   (dl),
    .i_SAMPLES_NUMBER(nsamp),
    .o_BF_VALID      (bf_valid),
    .i_BF_READY      (rdy),
    .o_ADDR_A        (a),
    .o_ADDR_B        (b),
    .o_TWIDDLE       (tw),
    .o_STAGE         (st),
    .i_WB_DONE       (wb),
    .o_BUSY          (busy),
    .o_CALC_END      (cend),
    .o_ERR           (err)
  );

  always #5 i_clk = ~i_clk;

  // Reference DIF walk against a 2048-point twiddle table.
  function automatic void push_expected(int n);
    int l = 0;
    while ((1 << l) < n) l++;
    for (int s = 0; s < l; s++) begin
      int span;
      span = n >> (s + 1);
      for (int g = 0; g < n; g += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          cmd_t c;
          c.a  = AW'(g + j);
          c.b  = AW'(g + j + span);
          c.tw = TW'(j << (s + 11 - l));
          c.st = SW'(s);
          sb.push_back(c);
        end
      end
    end
  endfunction

  // One cycle: deliver an owed write-back, sample outputs, present ready for the coming edge.
  task automatic tick(input bit r, output bit x, output bit wd, output cmd_t obs);
    @(negedge i_clk);
    dl = 1'b0;
    wd = !wb_hold && (wb_owed > 0);
    wb = wd;
    if (wd) wb_owed--;
    rdy = r;
    obs = {a, b, tw, st};
    x = bf_valid && r;
    if (x) wb_owed++;
  endtask

  task automatic start(input logic [AW-1:0] n);
    @(negedge i_clk);
    nsamp = n;
    dl    = 1'b1;
    wb    = 1'b0;
    rdy   = 1'b0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; dl = 1'b0; rdy = 1'b0; wb = 1'b0; nsamp = '0;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({bf_valid, busy, cend, err} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {bf_valid, busy, cend, err});
    end
    checks++;
    if ({a, b, tw, st} !== '0) begin
      errors++; $display("FAIL reset_cmd: got a=%0d b=%0d tw=%0d st=%0d want all 0", a, b, tw, st);
    end
    i_rstn = 1'b1;
  endtask

  task automatic test_n8();
    cmd_t obs, exp;
    bit x, wd;
    int nx = 0, nwb = 0, wb12 = -1, cend_at = -1;
    push_expected(8);
    start(8);
    for (int c = 0; c < 100 && cend_at < 0; c++) begin
      tick(1'b1, x, wd, obs);
      if (c == 0) begin
        checks++;
        if (bf_valid !== 1'b1) begin errors++; $display("FAIL n8_first_valid: got %b want 1", bf_valid); end
      end
      if (wd) begin nwb++; if (nwb == 12) wb12 = c; end
      if (cend) cend_at = c;
      if (x) begin
        nx++; checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        if (obs !== exp) begin
          errors++; $display("FAIL n8_cmd: got %h want %h", obs, exp);
        end
      end
    end
    checks++;
    if (cend_at < 0 || cend_at != wb12 + 1) begin
      errors++; $display("FAIL n8_calc_end: got cycle %0d want %0d", cend_at, wb12 + 1);
    end
    checks++;
    if (nx != 12) begin errors++; $display("FAIL n8_count: got %0d want 12", nx); end
  endtask

  task automatic test_backpressure();
    cmd_t obs, exp, prev_obs;
    bit x, wd, r, prev_stall = 0, done = 0;
    int nx = 0;
    push_expected(16);
    start(16);
    for (int c = 0; c < 500 && !done; c++) begin
      r = 1'($urandom_range(0, 1));
      tick(r, x, wd, obs);
      if (prev_stall) begin
        checks++;
        if (obs !== prev_obs) begin
          errors++; $display("FAIL bp_hold: got %h want %h", obs, prev_obs);
        end
      end
      prev_stall = bf_valid && !r;
      prev_obs   = obs;
      if (x) begin
        nx++; checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        if (obs !== exp) begin errors++; $display("FAIL bp_cmd: got %h want %h", obs, exp); end
      end
      if (cend) done = 1;
    end
    checks++;
    if (!done || nx != 32 || sb.size() != 0) begin
      errors++; $display("FAIL bp_total: got done=%0d xfers=%0d left=%0d want 1/32/0", done, nx,
                         sb.size());
    end
  endtask

  task automatic test_drain_hazard();
    cmd_t obs, exp;
    bit x, wd, done = 0;
    int nx = 0, nwb = 0, wb4 = -1, held = 0;
    push_expected(8);
    wb_hold = 1;
    start(8);
    for (int c = 0; c < 200 && !done; c++) begin
      if (nx >= 4 && wb_hold) begin held++; if (held > 20) wb_hold = 0; end
      tick(1'b1, x, wd, obs);
      if (wd) begin nwb++; if (nwb == 4) wb4 = c; end
      if (nx >= 4 && (wb4 < 0 || c == wb4)) begin
        checks++;
        if (bf_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bf_valid); end
      end
      if (wb4 >= 0 && c == wb4 + 1) begin
        checks++;
        if (bf_valid !== 1'b1 || st !== SW'(1)) begin
          errors++; $display("FAIL drain_resume: got valid=%b st=%0d want 1/1", bf_valid, st);
        end
      end
      if (x) begin
        nx++; checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        if (obs !== exp) begin errors++; $display("FAIL drain_cmd: got %h want %h", obs, exp); end
      end
      if (cend) done = 1;
    end
    wb_hold = 0;
    checks++;
    if (!done || nx != 12) begin
      errors++; $display("FAIL drain_total: got done=%0d xfers=%0d want 1/12", done, nx);
    end
  endtask

  task automatic test_invalid();
    cmd_t obs, exp;
    bit x, wd, done = 0;
    int nx = 0;
    logic [AW-1:0] bad[3];
    bad[0] = AW'(6); bad[1] = AW'(2); bad[2] = AW'(4096);
    for (int i = 0; i < 3; i++) begin
      start(bad[i]);
      for (int k = 0; k < 4; k++) begin
        tick(1'b1, x, wd, obs);
        checks++;
        if (bf_valid !== 1'b0) begin errors++; $display("FAIL inv_valid: got %b want 0", bf_valid); end
      end
      checks++;
      if ({err, cend, busy} !== 3'b100) begin
        errors++; $display("FAIL inv_err: got err/cend/busy=%b want 100", {err, cend, busy});
      end
    end
    push_expected(4);
    start(4);
    for (int c = 0; c < 50 && !done; c++) begin
      tick(1'b1, x, wd, obs);
      if (c == 0) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL inv_err_clear: got %b want 0", err); end
      end
      if (x) begin
        nx++; checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        if (obs !== exp) begin errors++; $display("FAIL n4_cmd: got %h want %h", obs, exp); end
      end
      if (cend) done = 1;
    end
    checks++;
    if (!done || nx != 4) begin errors++; $display("FAIL n4_total: got %0d/%0d want 1/4", done, nx); end
    // A write-back with nothing outstanding is an error.
    wb_owed = 1;
    tick(1'b0, x, wd, obs);
    tick(1'b0, x, wd, obs);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL stray_wb: got err=%b want 1", err); end
  endtask

  task automatic test_full();
    cmd_t obs, exp;
    bit x, wd, done = 0;
    int nx = 0, maxst = 0;
    push_expected(2048);
    start(12'd2048);
    for (int c = 0; c < 13000 && !done; c++) begin
      tick(1'b1, x, wd, obs);
      if (int'(st) > maxst) maxst = int'(st);
      if (x) begin
        nx++; checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        if (obs !== exp) begin errors++; $display("FAIL full_cmd: got %h want %h", obs, exp); end
      end
      if (cend) done = 1;
    end
    checks++;
    if (!done || nx != 11264 || maxst != 10) begin
      errors++; $display("FAIL full_total: got done=%0d xfers=%0d maxst=%0d want 1/11264/10", done,
                         nx, maxst);
    end
    push_expected(4);
    start(4);
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      tick(1'b1, x, wd, obs);
      if (c == 0) begin
        checks++;
        if (cend !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL restart: got cend=%b busy=%b want 0/1", cend, busy);
        end
      end
      if (x) begin
        checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        if (obs !== exp) begin errors++; $display("FAIL restart_cmd: got %h want %h", obs, exp); end
      end
      if (cend) done = 1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL restart_done: got 0 want 1"); end
  endtask

  task automatic test_reset_midop();
    cmd_t obs, exp, first;
    bit x, wd, done = 0;
    int s1 = 0;
    push_expected(64);
    start(64);
    for (int c = 0; c < 300; c++) begin
      tick(1'b1, x, wd, obs);
      if (x) begin
        checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        if (obs !== exp) begin errors++; $display("FAIL mid_cmd: got %h want %h", obs, exp); end
        if (st == SW'(1)) s1++;
      end
      if (s1 >= 3) break;
    end
    i_rstn = 1'b0;
    #1;
    checks++;
    if (s1 < 3 || {bf_valid, busy, cend, err} !== 4'b0 || {a, b, tw, st} !== '0) begin
      errors++; $display("FAIL mid_reset: got s1=%0d flags=%b a=%0d b=%0d tw=%0d st=%0d want 0s", s1,
                         {bf_valid, busy, cend, err}, a, b, tw, st);
    end
    sb.delete();
    wb_owed = 0; wb = 1'b0; rdy = 1'b0; dl = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    push_expected(64);
    start(64);
    first = {12'd0, 12'd32, 11'd0, 4'd0};
    tick(1'b1, x, wd, obs);
    checks++;
    if (!x || obs !== first) begin
      errors++; $display("FAIL mid_restart: got x=%b %h want 1 %h", x, obs, first);
    end
    if (x && sb.size() > 0) exp = sb.pop_front();
    for (int c = 0; c < 400 && !done; c++) begin
      tick(1'b1, x, wd, obs);
      if (x) begin
        checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        if (obs !== exp) begin errors++; $display("FAIL n64_cmd: got %h want %h", obs, exp); end
      end
      if (cend) done = 1;
    end
    checks++;
    if (!done || sb.size() != 0) begin
      errors++; $display("FAIL n64_done: got done=%0d left=%0d want 1/0", done, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_n8();
    test_backpressure();
    test_drain_hazard();
    test_invalid();
    test_full();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
